// File: rtl/dds_chirp_pkg.sv
// Shared types and defaults for the DDS chirp receiver: handshake FSM states,
// the chirp parameter record and default datapath widths.
package dds_chirp_pkg;

  localparam int ACC_W_DEF  = 48;
  localparam int RATE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACKH = 2'd2
  } hs_state_e;

  typedef struct packed {
    logic [ACC_W_DEF-1:0]  freq;
    logic [ACC_W_DEF-1:0]  delta_freq;
    logic [RATE_W_DEF-1:0] delta_rate;
  } dds_param_t;

endpackage

// File: rtl/dds_chirp_rx_sync_ff.sv
// Single-bit multi-flop synchronizer with synchronous clear.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dds_chirp_rx.sv
// DDS-side REQ/ACK parameter receiver and linear-FM chirp generator.
// Optional status outputs (XFER_CNT, PARAM_LOST) under DDS_CHIRP_RX_STATUS_EN.
module dds_chirp_rx
  import dds_chirp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int RATE_W      = RATE_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  output logic              ACK,
  input  logic [ACC_W-1:0]  DDS_freq,
  input  logic [ACC_W-1:0]  DDS_delta_freq,
  input  logic [RATE_W-1:0] DDS_delta_rate,
  input  logic              DDS_start,
  output logic [ACC_W-1:0]  PHASE,
  output logic [ACC_W-1:0]  FREQ_CUR,
  output logic              RUN,
  output logic              NEW_PARAM
`ifdef DDS_CHIRP_RX_STATUS_EN
  ,
  output logic [15:0]       XFER_CNT,
  output logic [0:0]        PARAM_LOST
`endif
);

  hs_state_e         state;
  logic              req_s;
  logic              start_s;
  logic              start_d1;
  logic              start_rise;
  logic              capt;

  logic [ACC_W-1:0]  sh_freq;
  logic [ACC_W-1:0]  sh_df;
  logic [RATE_W-1:0] sh_rate;
  logic [ACC_W-1:0]  act_freq;
  logic [ACC_W-1:0]  act_df;
  logic [RATE_W-1:0] act_rate;
  logic [RATE_W-1:0] rate_cnt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (CLK),
    .rst (RESET),
    .d   (REQ),
    .q   (req_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk (CLK),
    .rst (RESET),
    .d   (DDS_start),
    .q   (start_s)
  );

  assign start_rise = start_s & ~start_d1;
  assign capt       = (state == CAPT);
  assign RUN        = start_s;

  // Handshake: ACK stays high until REQ is seen low, so a held REQ never recaptures
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ACK   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_s) state <= CAPT;
        CAPT: begin
          state <= ACKH;
          ACK   <= 1'b1;
        end
        ACKH: if (!req_s) begin
          state <= IDLE;
          ACK   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ACK   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_freq <= '0;
      sh_df   <= '0;
      sh_rate <= '0;
    end else if (capt) begin
      sh_freq <= DDS_freq;
      sh_df   <= DDS_delta_freq;
      sh_rate <= DDS_delta_rate;
    end
  end

  // A capture coinciding with a load wins: the fresh shadow is still unconsumed
  always_ff @(posedge CLK) begin
    if (RESET)           NEW_PARAM <= 1'b0;
    else if (capt)       NEW_PARAM <= 1'b1;
    else if (start_rise) NEW_PARAM <= 1'b0;
  end

  // Chirp generator: active set only changes on a start edge, keeping bursts coherent
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_d1 <= 1'b0;
      act_freq <= '0;
      act_df   <= '0;
      act_rate <= '0;
      rate_cnt <= '0;
      FREQ_CUR <= '0;
      PHASE    <= '0;
    end else begin
      start_d1 <= start_s;
      if (start_rise) begin
        act_freq <= sh_freq;
        act_df   <= sh_df;
        act_rate <= sh_rate;
        rate_cnt <= sh_rate;
        FREQ_CUR <= sh_freq;
        PHASE    <= '0;
      end else if (start_s) begin
        PHASE <= PHASE + FREQ_CUR;
        if (rate_cnt == '0) begin
          rate_cnt <= act_rate;
          FREQ_CUR <= FREQ_CUR + act_df;
        end else begin
          rate_cnt <= rate_cnt - 1'b1;
        end
      end else begin
        PHASE    <= '0;
        FREQ_CUR <= act_freq;
      end
    end
  end

`ifdef DDS_CHIRP_RX_STATUS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      XFER_CNT   <= '0;
      PARAM_LOST <= 1'b0;
    end else begin
      if (state == ACKH && !req_s) XFER_CNT <= XFER_CNT + 16'd1;
      if (capt && NEW_PARAM)       PARAM_LOST <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dds_chirp_rx.sv
// Self-checking bench for dds_chirp_rx: handshake latency, ramp, wrap,
// coherent update, reset mid-handshake and optional status outputs.
module tb_dds_chirp_rx;
  import dds_chirp_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ;
  logic        ACK;
  logic [47:0] DDS_freq;
  logic [47:0] DDS_delta_freq;
  logic [31:0] DDS_delta_rate;
  logic        DDS_start;
  logic [47:0] PHASE;
  logic [47:0] FREQ_CUR;
  logic        RUN;
  logic        NEW_PARAM;
`ifdef DDS_CHIRP_RX_STATUS_EN
  logic [15:0] XFER_CNT;
  logic [0:0]  PARAM_LOST;
`endif

  dds_chirp_rx #(.SYNC_STAGES(2), .ACC_W(48), .RATE_W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .REQ            (REQ),
    .ACK            (ACK),
    .DDS_freq       (DDS_freq),
    .DDS_delta_freq (DDS_delta_freq),
    .DDS_delta_rate (DDS_delta_rate),
    .DDS_start      (DDS_start),
    .PHASE          (PHASE),
    .FREQ_CUR       (FREQ_CUR),
    .RUN            (RUN),
    .NEW_PARAM      (NEW_PARAM)
`ifdef DDS_CHIRP_RX_STATUS_EN
    ,
    .XFER_CNT       (XFER_CNT),
    .PARAM_LOST     (PARAM_LOST)
`endif
  );

  always #5 CLK = ~CLK;

  int clk_n = 0;
  always @(posedge CLK) clk_n <= clk_n + 1;

  typedef struct {
    dds_param_t  p;
    int          cyc;
    logic [47:0] exp_fc;
  } vec_t;

  typedef struct {
    logic [47:0] fc;
    logic [47:0] ph;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference ramp: frequency steps once every (rate+1) clocks after the load
  function automatic logic [47:0] ref_fc(input dds_param_t p, input int n);
    int steps;
    steps = n / (int'(p.delta_rate) + 1);
    return p.freq + p.delta_freq * 48'(steps);
  endfunction

  function automatic logic [47:0] ref_ph(input dds_param_t p, input int n);
    logic [47:0] acc;
    acc = '0;
    for (int j = 0; j < n; j++) acc = acc + ref_fc(p, j);
    return acc;
  endfunction

  // Returns the number of falling edges until sel (0=ACK, 1=RUN) equals val, or -1
  task automatic wait_for(input int sel, input logic val, input string nm, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      s = (sel == 0) ? ACK : RUN;
      if (s === val) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no transition, expected %b", nm, val);
    end
  endtask

  task automatic handshake(input dds_param_t p);
    int n;
    DDS_freq       = p.freq;
    DDS_delta_freq = p.delta_freq;
    DDS_delta_rate = p.delta_rate;
    REQ = 1'b1;
    wait_for(0, 1'b1, "ack_rise", n);
    if (n > 0) chk("ack_rise_lat", 64'(n), 64'd4);
    chk("new_param_set", 64'(NEW_PARAM), 64'd1);
    REQ = 1'b0;
    wait_for(0, 1'b0, "ack_fall", n);
    if (n > 0) chk("ack_fall_lat", 64'(n), 64'd3);
  endtask

  task automatic start_chirp();
    int n;
    DDS_start = 1'b1;
    wait_for(1, 1'b1, "run_rise", n);
    @(negedge CLK);
  endtask

  task automatic stop_chirp();
    int n;
    DDS_start = 1'b0;
    wait_for(1, 1'b0, "run_fall", n);
    @(negedge CLK);
  endtask

  vec_t vt[4];

  initial begin
    dds_param_t p;
    exp_t e;
    int n;
    int load_n;

    vt[0] = '{p: '{freq: 48'h1000, delta_freq: 48'h10, delta_rate: 32'd3}, cyc: 8, exp_fc: 48'h1020};
    vt[1] = '{p: '{freq: 48'hFFFF_FFFF_FFF0, delta_freq: 48'h20, delta_rate: 32'd0}, cyc: 3, exp_fc: 48'h50};
    vt[2] = '{p: '{freq: 48'h5, delta_freq: 48'h3, delta_rate: 32'd1}, cyc: 6, exp_fc: 48'hE};
    vt[3] = '{p: '{freq: 48'h0, delta_freq: 48'hFFFF_FFFF_FFFF, delta_rate: 32'd0}, cyc: 3, exp_fc: 48'hFFFF_FFFF_FFFD};

    RESET = 1'b1;
    REQ = 1'b0;
    DDS_start = 1'b0;
    DDS_freq = '0;
    DDS_delta_freq = '0;
    DDS_delta_rate = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ack", 64'(ACK), 64'd0);
    chk("rst_phase", 64'(PHASE), 64'd0);
    chk("rst_freq", 64'(FREQ_CUR), 64'd0);
    chk("rst_run", 64'(RUN), 64'd0);
    chk("rst_new_param", 64'(NEW_PARAM), 64'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 4; v++) begin
      handshake(vt[v].p);
      DDS_start = 1'b1;
      for (int k = 0; k <= vt[v].cyc; k++) begin
        e.fc = ref_fc(vt[v].p, k);
        e.ph = ref_ph(vt[v].p, k);
        sb.push_back(e);
      end
      wait_for(1, 1'b1, "run_rise", n);
      for (int k = 0; k <= vt[v].cyc; k++) begin
        @(negedge CLK);
        e = sb.pop_front();
        chk($sformatf("v%0d_fc_%0d", v, k), 64'(FREQ_CUR), 64'(e.fc));
        chk($sformatf("v%0d_ph_%0d", v, k), 64'(PHASE), 64'(e.ph));
        if (k == 0) chk($sformatf("v%0d_new_param_clr", v), 64'(NEW_PARAM), 64'd0);
      end
      chk($sformatf("v%0d_final_fc", v), 64'(FREQ_CUR), 64'(vt[v].exp_fc));
      stop_chirp();
      chk($sformatf("v%0d_idle_fc", v), 64'(FREQ_CUR), 64'(vt[v].p.freq));
      chk($sformatf("v%0d_idle_ph", v), 64'(PHASE), 64'd0);
    end

    // Coherent update: a transfer during a running chirp leaves the ramp alone
    p = '{freq: 48'h1000, delta_freq: 48'h10, delta_rate: 32'd3};
    handshake(p);
    start_chirp();
    load_n = clk_n;
    handshake('{freq: 48'h2000, delta_freq: 48'h10, delta_rate: 32'd3});
    n = clk_n - load_n;
    chk("coh_fc", 64'(FREQ_CUR), 64'(ref_fc(p, n)));
    chk("coh_ph", 64'(PHASE), 64'(ref_ph(p, n)));
    stop_chirp();
    chk("coh_idle_fc", 64'(FREQ_CUR), 64'h1000);
    chk("coh_new_param_held", 64'(NEW_PARAM), 64'd1);
    start_chirp();
    chk("coh_reload_fc", 64'(FREQ_CUR), 64'h2000);
    chk("coh_reload_new_param", 64'(NEW_PARAM), 64'd0);

    // Reset while ACK is high and the chirp is running; REQ stays asserted
    DDS_freq = 48'h3000;
    DDS_delta_freq = 48'h1;
    DDS_delta_rate = 32'd0;
    REQ = 1'b1;
    wait_for(0, 1'b1, "rst_ack_rise", n);
    RESET = 1'b1;
    DDS_start = 1'b0;
    @(negedge CLK);
    chk("midrst_ack", 64'(ACK), 64'd0);
    chk("midrst_fc", 64'(FREQ_CUR), 64'd0);
    chk("midrst_ph", 64'(PHASE), 64'd0);
    chk("midrst_run", 64'(RUN), 64'd0);
    RESET = 1'b0;
    wait_for(0, 1'b1, "recapt_ack", n);
    if (n > 0) chk("recapt_lat", 64'(n), 64'd4);
    chk("recapt_new_param", 64'(NEW_PARAM), 64'd1);
    REQ = 1'b0;
    wait_for(0, 1'b0, "recapt_fall", n);
    if (n > 0) chk("recapt_fall_lat", 64'(n), 64'd3);
`ifdef DDS_CHIRP_RX_STATUS_EN
    chk("xfer_cnt_1", 64'(XFER_CNT), 64'd1);
    chk("param_lost_0", 64'(PARAM_LOST), 64'd0);
`endif

    // Second transfer with no start in between overwrites unconsumed shadow
    handshake('{freq: 48'h4000, delta_freq: 48'h2, delta_rate: 32'd1});
`ifdef DDS_CHIRP_RX_STATUS_EN
    chk("xfer_cnt_2", 64'(XFER_CNT), 64'd2);
    chk("param_lost_1", 64'(PARAM_LOST), 64'd1);
`endif
    start_chirp();
    chk("final_load_fc", 64'(FREQ_CUR), 64'h4000);
    chk("final_new_param", 64'(NEW_PARAM), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
